// File: rtl/bcd_counter_mux.sv
// Multi-digit BCD up/down counter with prescaled count tick, parallel load,
// and a time-multiplexed 7-segment scan output with optional leading-zero blanking.
module bcd_counter_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 1000,
  parameter int SCAN_DIV       = 250,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    wrap
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_INV   = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'h3F;
      4'd1:    seg_pattern = 7'h06;
      4'd2:    seg_pattern = 7'h5B;
      4'd3:    seg_pattern = 7'h4F;
      4'd4:    seg_pattern = 7'h66;
      4'd5:    seg_pattern = 7'h6D;
      4'd6:    seg_pattern = 7'h7D;
      4'd7:    seg_pattern = 7'h07;
      4'd8:    seg_pattern = 7'h7F;
      4'd9:    seg_pattern = 7'h6F;
      default: seg_pattern = 7'h00;
    endcase
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  tick;
  logic [CW-1:0]         step_val;
  logic                  step_carry;
  logic [CW-1:0]         clamp_val;
  logic [3:0]            cur_digit;
  logic                  blank;

  assign tick = enable && (presc_q == PRESC_MAX);

  // Ripple the carry/borrow through the digits; a carry out of the top digit is a roll-over.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    step_val   = count_q;
    step_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (step_carry) begin
        if (up_down) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            step_carry         = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            step_carry         = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamp_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      clamp_val[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = clamp_val;
      presc_d = '0;
    end else if (enable) begin
      if (tick) begin
        presc_d = '0;
        count_d = step_val;
        wrap_d  = step_carry;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Display path looks at next-state count and index so segments and select always match.
  always_comb begin
    scan_d = scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    sel_d     = NUM_DIGITS'(1) << idx_d;
    cur_digit = count_d[{idx_d, 2'b00} +: 4];
    blank     = blank_lz && (idx_d != '0) && ((count_d >> {idx_d, 2'b00}) == '0);
    seg_d     = (blank ? 7'h00 : seg_pattern(cur_digit)) ^ SEG_INV;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      seg_q   <= 7'h3F ^ SEG_INV;
      sel_q   <= NUM_DIGITS'(1);
    end else begin
      presc_q <= presc_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign seg_out   = seg_q;
  assign digit_sel = sel_q;
  assign count     = count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_counter_mux.sv
// Self-checking bench: two configurations of bcd_counter_mux compared each cycle
// against an arithmetic reference model, plus directed tables and corner sequences.
module tb_bcd_counter_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 3 digits, tick every enabled cycle, active-high segments.
  logic        a_en, a_ud, a_ld, a_blz;
  logic [11:0] a_lv, a_cnt;
  logic [6:0]  a_seg;
  logic [2:0]  a_sel;
  logic        a_wrap;

  // Instance B: 4 digits, prescaled tick, active-low segments.
  logic        b_en, b_ud, b_ld, b_blz;
  logic [15:0] b_lv, b_cnt;
  logic [6:0]  b_seg;
  logic [3:0]  b_sel;
  logic        b_wrap;

  bcd_counter_mux #(.NUM_DIGITS(3), .TICK_DIV(1), .SCAN_DIV(3), .ACTIVE_LOW_SEG(1'b0)) dut_a (
    .clk(clk), .rst(rst), .enable(a_en), .up_down(a_ud), .load(a_ld), .load_val(a_lv),
    .blank_lz(a_blz), .seg_out(a_seg), .digit_sel(a_sel), .count(a_cnt), .wrap(a_wrap)
  );

  bcd_counter_mux #(.NUM_DIGITS(4), .TICK_DIV(3), .SCAN_DIV(2), .ACTIVE_LOW_SEG(1'b1)) dut_b (
    .clk(clk), .rst(rst), .enable(b_en), .up_down(b_ud), .load(b_ld), .load_val(b_lv),
    .blank_lz(b_blz), .seg_out(b_seg), .digit_sel(b_sel), .count(b_cnt), .wrap(b_wrap)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] seg_tab [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  typedef struct packed {
    int   val;
    int   presc;
    int   scan;
    int   idx;
    logic wrap;
    logic blz;
  } mstate_t;

  mstate_t ma, mb;
  bit      mvalid = 1'b0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) r = r | (32'((v / pow10(i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic int from_clamped(input logic [31:0] lv, input int nd);
    int r = 0;
    for (int i = 0; i < nd; i++) begin
      int d = int'((lv >> (4 * i)) & 32'hF);
      if (d > 9) d = 9;
      r = r + d * pow10(i);
    end
    return r;
  endfunction

  function automatic mstate_t mstep(input mstate_t m, input int nd, input int tdiv, input int sdiv,
                                    input logic r, input logic en, input logic ud, input logic ld,
                                    input logic blz, input logic [31:0] lv);
    mstate_t n = m;
    int modv = pow10(nd);
    n.blz  = blz;
    n.wrap = 1'b0;
    if (r) begin
      n.val = 0; n.presc = 0; n.scan = 0; n.idx = 0;
      return n;
    end
    if (m.scan == sdiv - 1) begin
      n.scan = 0;
      n.idx  = (m.idx + 1) % nd;
    end else begin
      n.scan = m.scan + 1;
    end
    if (ld) begin
      n.val   = from_clamped(lv, nd);
      n.presc = 0;
    end else if (en) begin
      if (m.presc == tdiv - 1) begin
        n.presc = 0;
        if (ud) begin
          n.wrap = (m.val == modv - 1);
          n.val  = (m.val + 1) % modv;
        end else begin
          n.wrap = (m.val == 0);
          n.val  = (m.val + modv - 1) % modv;
        end
      end else begin
        n.presc = m.presc + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_seg(input mstate_t m, input bit active_low);
    int   upper = m.val / pow10(m.idx);
    logic [6:0] p;
    p = (m.blz && m.idx > 0 && upper == 0) ? 7'h00 : seg_tab[upper % 10];
    return {25'd0, active_low ? (p ^ 7'h7F) : p};
  endfunction

  // One clock: advance both models with the inputs present at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    ma = mstep(ma, 3, 1, 3, rst, a_en, a_ud, a_ld, a_blz, {20'd0, a_lv});
    mb = mstep(mb, 4, 3, 2, rst, b_en, b_ud, b_ld, b_blz, {16'd0, b_lv});
    if (rst) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      check("a_count_model", a_cnt, to_bcd(ma.val, 3));
      check("a_wrap_model",  a_wrap, ma.wrap);
      check("a_sel_model",   a_sel, 32'(1) << ma.idx);
      check("a_seg_model",   a_seg, exp_seg(ma, 1'b0));
      check("b_count_model", b_cnt, to_bcd(mb.val, 4));
      check("b_wrap_model",  b_wrap, mb.wrap);
      check("b_sel_model",   b_sel, 32'(1) << mb.idx);
      check("b_seg_model",   b_seg, exp_seg(mb, 1'b1));
    end
  endtask

  // ---------------- directed tables ----------------
  typedef struct packed {
    logic        ud;
    logic [11:0] lv;
    logic [11:0] exp;
  } ld_vec_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
  } scan_vec_t;

  ld_vec_t   ld_tab   [5];
  scan_vec_t scan_tab [7];
  logic [6:0] blank_on  [3];
  logic [6:0] blank_off [3];

  initial begin
    seg_tab   = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    ld_tab[0] = '{1'b1, 12'h0A5, 12'h095};
    ld_tab[1] = '{1'b1, 12'hFFF, 12'h999};
    ld_tab[2] = '{1'b1, 12'h999, 12'h999};
    ld_tab[3] = '{1'b0, 12'hB0C, 12'h909};
    ld_tab[4] = '{1'b0, 12'h000, 12'h000};
    scan_tab[0] = '{4'b0010, 7'h4F ^ 7'h7F};
    scan_tab[1] = '{4'b0010, 7'h4F ^ 7'h7F};
    scan_tab[2] = '{4'b0100, 7'h5B ^ 7'h7F};
    scan_tab[3] = '{4'b0100, 7'h5B ^ 7'h7F};
    scan_tab[4] = '{4'b1000, 7'h06 ^ 7'h7F};
    scan_tab[5] = '{4'b1000, 7'h06 ^ 7'h7F};
    scan_tab[6] = '{4'b0001, 7'h66 ^ 7'h7F};
    blank_on  = '{7'h07, 7'h00, 7'h00};
    blank_off = '{7'h07, 7'h3F, 7'h3F};

    a_en = 0; a_ud = 1; a_ld = 0; a_blz = 0; a_lv = '0;
    b_en = 0; b_ud = 1; b_ld = 0; b_blz = 0; b_lv = '0;

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_a_count", a_cnt, 0);
    check("rst_a_sel", a_sel, 3'b001);
    check("rst_a_seg", a_seg, 7'h3F);
    check("rst_a_wrap", a_wrap, 0);
    check("rst_b_sel", b_sel, 4'b0001);
    check("rst_b_seg", b_seg, 7'h40);
    rst = 1'b0;

    // Count up through full range and roll over
    a_en = 1; a_ud = 1;
    repeat (999) cycle();
    check("up_999_count", a_cnt, 12'h999);
    check("up_999_wrap", a_wrap, 0);
    cycle();
    check("up_roll_count", a_cnt, 12'h000);
    check("up_roll_wrap", a_wrap, 1);
    cycle();
    check("up_after_count", a_cnt, 12'h001);
    check("up_after_wrap", a_wrap, 0);

    // Count down from zero, then hold with enable low
    rst = 1'b1; cycle(); rst = 1'b0;
    a_ud = 0; a_en = 1;
    cycle();
    check("down_roll_count", a_cnt, 12'h999);
    check("down_roll_wrap", a_wrap, 1);
    a_en = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("hold_count", a_cnt, 12'h999);
      check("hold_wrap", a_wrap, 0);
    end

    // Load with simultaneous tick: load wins, digits clamped, no wrap
    for (int i = 0; i < 5; i++) begin
      a_en = 1; a_ld = 1; a_ud = ld_tab[i].ud; a_lv = ld_tab[i].lv;
      cycle();
      check("load_count", a_cnt, ld_tab[i].exp);
      check("load_wrap", a_wrap, 0);
    end
    a_ld = 0; a_en = 0;

    // Load clears the prescaler (instance B, TICK_DIV=3)
    rst = 1'b1; cycle(); rst = 1'b0;
    b_en = 1; b_ud = 1;
    cycle();
    b_ld = 1; b_lv = 16'h0042;
    cycle();
    check("presc_load_count", b_cnt, 16'h0042);
    b_ld = 0;
    cycle(); cycle();
    check("presc_cleared_hold", b_cnt, 16'h0042);
    cycle();
    check("presc_cleared_tick", b_cnt, 16'h0043);
    b_en = 0;

    // Scan of 1234 on instance B (SCAN_DIV=2, active-low)
    rst = 1'b1; cycle(); rst = 1'b0;
    check("scan_start_sel", b_sel, 4'b0001);
    b_ld = 1; b_lv = 16'h1234; b_blz = 0;
    cycle();
    b_ld = 0;
    check("scan_d0_sel", b_sel, 4'b0001);
    check("scan_d0_seg", b_seg, 7'h66 ^ 7'h7F);
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("scan_sel", b_sel, scan_tab[i].sel);
      check("scan_seg", b_seg, scan_tab[i].seg);
    end

    // Leading-zero blanking on instance A (SCAN_DIV=3): idx at edge k is (k/3)%3
    rst = 1'b1; cycle(); rst = 1'b0;
    a_en = 0; a_ld = 1; a_lv = 12'h007; a_blz = 1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 2)  a_ld = 0;
      if (k == 10) a_blz = 0;
      cycle();
      check("blz_sel", a_sel, 32'(1) << ((k / 3) % 3));
      check("blz_seg", a_seg, (k < 10) ? blank_on[(k / 3) % 3] : blank_off[(k / 3) % 3]);
    end
    a_ld = 1; a_lv = 12'h000; a_blz = 1;
    cycle();
    check("zero_d0_seg", a_seg, 7'h3F);
    a_ld = 0;
    cycle();
    check("zero_d0_seg2", a_seg, 7'h3F);
    cycle();
    check("zero_d1_sel", a_sel, 3'b010);
    check("zero_d1_seg", a_seg, 7'h00);
    a_blz = 0;

    // Reset overrides load and tick mid-count
    a_en = 1; a_ud = 1; b_en = 1;
    repeat (17) cycle();
    rst = 1'b1; a_ld = 1; a_lv = 12'h555; b_ld = 1; b_lv = 16'h5555;
    cycle();
    check("rst_mid_a_count", a_cnt, 0);
    check("rst_mid_a_sel", a_sel, 3'b001);
    check("rst_mid_a_seg", a_seg, 7'h3F);
    check("rst_mid_a_wrap", a_wrap, 0);
    check("rst_mid_b_count", b_cnt, 0);
    check("rst_mid_b_sel", b_sel, 4'b0001);
    check("rst_mid_b_seg", b_seg, 7'h40);
    rst = 1'b0; a_ld = 0; b_ld = 0;
    cycle();
    check("rst_resume_a", a_cnt, 12'h001);

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      a_en  = ($urandom_range(0, 3) != 0);
      b_en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) a_ud = ~a_ud;
      if ($urandom_range(0, 49) == 0) b_ud = ~b_ud;
      a_blz = ($urandom_range(0, 1) == 1);
      b_blz = ($urandom_range(0, 1) == 1);
      a_ld  = ($urandom_range(0, 29) == 0);
      b_ld  = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       begin a_lv = 12'h999; b_lv = 16'h9999; end
        1:       begin a_lv = 12'h000; b_lv = 16'h0000; end
        2:       begin a_lv = 12'h998; b_lv = 16'h0001; end
        default: begin a_lv = 12'($urandom); b_lv = 16'($urandom); end
      endcase
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_counter_mux.md
BCD_COUNTER_MUX -- requirements
Module: bcd_counter_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of BCD digits (legal 2..8).
REQ-002 SHALL have parameter TICK_DIV, default 1000, clk cycles per count tick (>=1).
REQ-003 SHALL have parameter SCAN_DIV, default 250, clk cycles per display digit slot (>=1).
REQ-004 SHALL have parameter ACTIVE_LOW_SEG, default 0; 1 = invert seg_out.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port enable, input, 1, count enable (prescaler and count).
REQ-008 SHALL have port up_down, input, 1, 1 = count up, 0 = count down.
REQ-009 SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-010 SHALL have port load_val, input, 4*NUM_DIGITS, BCD load value, digit 0 in bits [3:0].
REQ-011 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-012 SHALL have port seg_out, output, 7, segments {g,f,e,d,c,b,a}, registered.
REQ-013 SHALL have port digit_sel, output, NUM_DIGITS, one-hot active-high digit enable, registered.
REQ-014 SHALL have port count, output, 4*NUM_DIGITS, current BCD count, registered.
REQ-015 SHALL have port wrap, output, 1, one-cycle pulse on count roll-over, registered.

Function
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 only while enable=1, hold while enable=0, and generate an internal tick in the cycle it equals TICK_DIV-1 (then return to 0); TICK_DIV=1 gives a tick every enabled cycle.
REQ-017 On tick with up_down=1, count SHALL BCD-increment: digit 9 -> 0 with carry into next digit; all-9s -> all-0s.
REQ-018 On tick with up_down=0, count SHALL BCD-decrement: digit 0 -> 9 with borrow; all-0s -> all-9s.
REQ-019 wrap SHALL be 1 for exactly the one cycle in which count first shows the rolled-over value (all-0s up, all-9s down), else 0.
REQ-020 count SHALL update one clk after the tick cycle; no change on non-tick cycles.
REQ-021 load=1 SHALL set count <= load_val on the next edge regardless of enable, take priority over a simultaneous tick, clear the prescaler to 0, and not assert wrap.
REQ-022 Any load_val digit >9 SHALL be loaded as 9 (per-digit clamp); count SHALL never hold a non-BCD digit.
REQ-023 Scan divider SHALL run freely (independent of enable/load), advancing digit index 0,1,..,NUM_DIGITS-1,0 once every SCAN_DIV cycles.
REQ-024 digit_sel SHALL have exactly one bit set, bit = index; digit 0 = least significant.
REQ-025 seg_out SHALL present the pattern of the digit currently selected, updated on the same edge as digit_sel (never mismatched), reflecting count as of that edge.
REQ-026 Patterns (ACTIVE_LOW_SEG=0), hex {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-027 With blank_lz=1, digit i>0 SHALL show 00 when it and all higher digits are 0; digit 0 is never blanked; blank_lz=0 disables blanking.
REQ-028 ACTIVE_LOW_SEG=1 SHALL bitwise-invert seg_out (blank = 7F); digit_sel polarity unaffected.

Reset
REQ-029 rst=1 at an edge SHALL force: count=0, prescaler=0, scan divider=0, index=0, digit_sel=one-hot bit 0, seg_out=3F (40 if ACTIVE_LOW_SEG), wrap=0.
REQ-030 rst SHALL override load, tick and scan in the same cycle; counting resumes from 0 the first cycle after rst deasserts.

Verification
REQ-031 NUM_DIGITS=3, TICK_DIV=1, up_down=1, enable=1 after reset: after 999 cycles count=999, wrap=0; next cycle count=000, wrap=1 for one cycle only.
REQ-032 From reset, up_down=0, TICK_DIV=1, one enabled cycle -> count=999, wrap=1; enable=0 for 10 cycles -> count held, wrap=0.
REQ-033 NUM_DIGITS=3: load=1 with load_val=0x0A5 and simultaneous tick -> count=095 next cycle, wrap=0, prescaler=0.
REQ-034 NUM_DIGITS=4, SCAN_DIV=2, count=1234: digit_sel 0001,0010,0100,1000,0001 each held 2 cycles; seg_out 66,4F,5B,06 respectively.
REQ-035 NUM_DIGITS=3, count=007, blank_lz=1: digits 2,1 seg_out=00, digit 0 seg_out=07; blank_lz=0 -> 3F,3F,07; count=000 -> digit 0 shows 3F.
REQ-036 rst=1 mid-count with load=1 and tick same cycle -> next cycle count=0, digit_sel bit 0, seg_out=3F, wrap=0.
